// File: rtl/irq_source_ctrl_pkg.sv
// irq_source_ctrl_pkg
// Shared definitions for the interrupt source controller.
//   IRQ_ID_W    : width of the claimed-line index (fixed at 3 bits)
//   MAX_IRQ     : largest supported number of interrupt lines
//   ST_*        : 2-bit encoding of the request/service FSM states
//   lowest_set  : fixed-priority encoder, the lowest set index wins
package irq_source_ctrl_pkg;

    localparam int IRQ_ID_W = 3;
    localparam int MAX_IRQ  = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_RETURN  = 2'd3;

    // Scans from the top down so that the last (lowest) set bit is the one kept.
    // An all-zero vector yields 0; callers only use the result when some bit is set.
    function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
        logic [IRQ_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IRQ_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_source_ctrl_sync_edge.sv
// irq_sync_edge
// Brings one asynchronous interrupt line into the clk domain through a
// two-flop synchronizer and flags a rising edge using a third flop.
// Ports:
//   clk       : system clock
//   nrst      : synchronous active-low reset
//   irq_async : raw external interrupt line
//   rise      : one-cycle pulse when a synchronized 0->1 transition is seen
module irq_sync_edge (
    input  logic clk,
    input  logic nrst,
    input  logic irq_async,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;
    logic [2:0] fill;

    // fill tracks how far genuine post-reset samples have travelled down the
    // pipeline. Until prev holds a real sample its reset value of 0 is
    // meaningless, so a line held high through reset must not look like an edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            fill <= 3'b000;
        end else begin
            meta <= irq_async;
            sync <= meta;
            prev <= sync;
            fill <= {fill[1:0], 1'b1};
        end
    end

    assign rise = fill[2] & sync & ~prev;

endmodule

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
// Collects rising edges on N_IRQ external interrupt lines into a pending
// register, selects the lowest-index pending and enabled line, and runs a
// simple non-nesting request/service handshake with the interrupt controller.
// Ports:
//   clk              : system clock, all state updates on the rising edge
//   nrst             : synchronous active-low reset
//   irq_in           : asynchronous interrupt lines, rising-edge sensitive
//   mask_we          : write strobe for the enable mask
//   mask_wdata       : new enable mask (1 = enabled)
//   sel_ISR          : controller has entered the ISR for the current request
//   ret_ISR          : controller is returning from the ISR
//   interrupt_signal : active-low request, low only while a request is open
//   irq_id           : index of the claimed or in-service line
//   irq_pending      : pending edge register
//   irq_mask         : current enable mask
//   in_service       : high while an ISR is being serviced
module irq_source_ctrl
    import irq_source_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N_IRQ-1:0]    irq_in,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_wdata,
    input  logic                sel_ISR,
    input  logic                ret_ISR,
    output logic                interrupt_signal,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [N_IRQ-1:0]    irq_pending,
    output logic [N_IRQ-1:0]    irq_mask,
    output logic                in_service
);

    logic [N_IRQ-1:0]    rise;
    logic [N_IRQ-1:0]    active;
    logic [MAX_IRQ-1:0]  active_ext;
    logic [IRQ_ID_W-1:0] winner;
    logic [N_IRQ-1:0]    claim_clr;
    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                start_req;
    logic                claim;
    logic                finish;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge u_sync_edge (
            .clk       (clk),
            .nrst      (nrst),
            .irq_async (irq_in[g]),
            .rise      (rise[g])
        );
    end

    // Zero-extending to the full 8-bit priority width means lines that do not
    // exist can never win arbitration.
    assign active     = irq_pending & irq_mask;
    assign active_ext = MAX_IRQ'(active);
    assign winner     = lowest_set(active_ext);

    assign start_req = (state == ST_IDLE)   && (active != '0);
    assign claim     = (state == ST_REQ)    && sel_ISR;
    assign finish    = (state == ST_RETURN) && !ret_ISR;

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            claim_clr[i] = claim && (irq_id == IRQ_ID_W'(i));
        end
    end

    // Once raised, a request is not withdrawn even if its line is masked;
    // it simply waits for sel_ISR.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_req) state_next = ST_REQ;
            ST_REQ:     if (sel_ISR)   state_next = ST_SERVICE;
            ST_SERVICE: if (ret_ISR)   state_next = ST_RETURN;
            ST_RETURN:  if (!ret_ISR)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state <= state_next;
            if (start_req) begin
                irq_id <= winner;
            end
            if (claim) begin
                in_service <= 1'b1;
            end else if (finish) begin
                in_service <= 1'b0;
            end
        end
    end

    // A fresh edge on the line being claimed in the same cycle keeps it
    // pending, because the set term is applied after the clear.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            irq_pending <= '0;
            irq_mask    <= '0;
        end else begin
            irq_pending <= (irq_pending & ~claim_clr) | rise;
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
        end
    end

    assign interrupt_signal = (state != ST_REQ);

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl
// Directed testbench for irq_source_ctrl. Each raised request is predicted
// (line index and the cycle it must appear) into a queue when the stimulus
// is issued; a monitor pops and compares whenever interrupt_signal falls.
module tb_irq_source_ctrl;
    import irq_source_ctrl_pkg::*;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N-1:0]    irq_in = '0;
    logic            mask_we = 1'b0;
    logic [N-1:0]    mask_wdata = '0;
    logic            sel_ISR = 1'b0;
    logic            ret_ISR = 1'b0;
    logic            interrupt_signal;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [N-1:0]    irq_pending;
    logic [N-1:0]    irq_mask;
    logic            in_service;

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    typedef struct {
        logic [IRQ_ID_W-1:0] id;
        int                  at;
    } req_t;

    req_t expq[$];

    irq_source_ctrl #(.N_IRQ(N)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .irq_in           (irq_in),
        .mask_we          (mask_we),
        .mask_wdata       (mask_wdata),
        .sel_ISR          (sel_ISR),
        .ret_ISR          (ret_ISR),
        .interrupt_signal (interrupt_signal),
        .irq_id           (irq_id),
        .irq_pending      (irq_pending),
        .irq_mask         (irq_mask),
        .in_service       (in_service)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Monitor: a falling interrupt_signal is the DUT presenting a request.
    logic prev_int = 1'b1;
    always @(negedge clk) begin
        req_t e;
        if (nrst && prev_int && !interrupt_signal) begin
            if (expq.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpected_request: got irq_id=%0d at cycle %0d, required none",
                         irq_id, cycle);
            end else begin
                e = expq.pop_front();
                checkOutput("request_id", 32'(irq_id), 32'(e.id));
                checkOutput("request_cycle", 32'(cycle), 32'(e.at));
            end
        end
        prev_int = interrupt_signal;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] lines);
        irq_in = lines;
    endtask

    task automatic expectRequest(input logic [IRQ_ID_W-1:0] id, input int delay);
        req_t e;
        e.id = id;
        e.at = cycle + delay;
        expq.push_back(e);
    endtask

    task automatic writeMask(input logic [N-1:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick(1);
        mask_we    = 1'b0;
    endtask

    task automatic waitRequest(input string name);
        int n;
        n = 0;
        while (interrupt_signal !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        if (interrupt_signal !== 1'b0) begin
            tests++;
            failed++;
            $display("[TB] FAIL %s_timeout: interrupt_signal=%b after 40 cycles, required 0",
                     name, interrupt_signal);
        end
    endtask

    task automatic claim();
        sel_ISR = 1'b1;
        tick(1);
        sel_ISR = 1'b0;
    endtask

    task automatic returnIsr(input bit expect_next, input logic [IRQ_ID_W-1:0] id);
        ret_ISR = 1'b1;
        tick(1);
        ret_ISR = 1'b0;
        if (expect_next) expectRequest(id, 2);
        tick(1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_interrupt_signal"}, 32'(interrupt_signal), 32'h1);
        checkOutput({tag, "_irq_id"}, 32'(irq_id), 32'h0);
        checkOutput({tag, "_irq_pending"}, 32'(irq_pending), 32'h0);
        checkOutput({tag, "_irq_mask"}, 32'(irq_mask), 32'h0);
        checkOutput({tag, "_in_service"}, 32'(in_service), 32'h0);
    endtask

    initial begin
        tick(3);
        checkResetState("reset");
        nrst = 1'b1;
        tick(1);

        // Single edge on line 5 with everything enabled.
        writeMask(8'hFF);
        applyStimulus(8'h20);
        expectRequest(3'd5, 4);
        waitRequest("t1");
        checkOutput("t1_pending_before_claim", 32'(irq_pending), 32'h20);
        claim();
        checkOutput("t1_int_after_claim", 32'(interrupt_signal), 32'h1);
        checkOutput("t1_in_service", 32'(in_service), 32'h1);
        checkOutput("t1_pending_after_claim", 32'(irq_pending), 32'h00);
        applyStimulus(8'h00);
        returnIsr(1'b0, 3'd0);
        checkOutput("t1_in_service_cleared", 32'(in_service), 32'h0);

        // Simultaneous edges on lines 6 and 2: lowest index first.
        applyStimulus(8'h44);
        expectRequest(3'd2, 4);
        waitRequest("t2a");
        checkOutput("t2_pending_both", 32'(irq_pending), 32'h44);
        claim();
        checkOutput("t2_pending_after_first", 32'(irq_pending), 32'h40);
        applyStimulus(8'h00);
        returnIsr(1'b1, 3'd6);
        waitRequest("t2b");
        claim();
        checkOutput("t2_pending_after_second", 32'(irq_pending), 32'h00);
        returnIsr(1'b0, 3'd0);

        // Masked edge stays pending and is requested once enabled.
        writeMask(8'h00);
        applyStimulus(8'h08);
        tick(6);
        checkOutput("t3_pending_masked", 32'(irq_pending), 32'h08);
        checkOutput("t3_int_masked", 32'(interrupt_signal), 32'h1);
        expectRequest(3'd3, 2);
        writeMask(8'h08);
        waitRequest("t3");
        claim();
        checkOutput("t3_pending_after_claim", 32'(irq_pending), 32'h00);
        applyStimulus(8'h00);
        returnIsr(1'b0, 3'd0);

        // New edge on line 4 lands in the same cycle the claim clears it.
        writeMask(8'hFF);
        applyStimulus(8'h10);
        expectRequest(3'd4, 4);
        waitRequest("t4a");
        applyStimulus(8'h00);
        tick(2);
        applyStimulus(8'h10);
        tick(2);
        claim();
        checkOutput("t4_in_service", 32'(in_service), 32'h1);
        checkOutput("t4_pending_kept", 32'(irq_pending), 32'h10);
        applyStimulus(8'h00);
        returnIsr(1'b1, 3'd4);
        waitRequest("t4b");
        claim();
        checkOutput("t4_pending_after_second", 32'(irq_pending), 32'h00);
        returnIsr(1'b0, 3'd0);

        // Masking the requested line while in REQ does not withdraw it.
        applyStimulus(8'h01);
        expectRequest(3'd0, 4);
        waitRequest("t5");
        writeMask(8'h00);
        checkOutput("t5_still_requesting", 32'(interrupt_signal), 32'h0);
        claim();
        checkOutput("t5_in_service", 32'(in_service), 32'h1);
        checkOutput("t5_pending_cleared", 32'(irq_pending), 32'h00);
        applyStimulus(8'h00);
        returnIsr(1'b0, 3'd0);
        writeMask(8'hFF);

        // Reset during SERVICE with line 1 held high throughout.
        applyStimulus(8'h02);
        expectRequest(3'd1, 4);
        waitRequest("t6a");
        claim();
        checkOutput("t6_in_service", 32'(in_service), 32'h1);
        nrst = 1'b0;
        tick(2);
        checkResetState("midreset");
        nrst = 1'b1;
        tick(10);
        checkOutput("t6_pending_after_reset", 32'(irq_pending), 32'h00);
        checkOutput("t6_int_after_reset", 32'(interrupt_signal), 32'h1);
        writeMask(8'hFF);
        tick(8);
        checkOutput("t6_pending_enabled", 32'(irq_pending), 32'h00);
        checkOutput("t6_int_enabled", 32'(interrupt_signal), 32'h1);
        applyStimulus(8'h00);
        tick(4);
        applyStimulus(8'h02);
        expectRequest(3'd1, 4);
        waitRequest("t6b");
        claim();
        returnIsr(1'b0, 3'd0);
        tick(3);

        checkOutput("leftover_expected_requests", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
IRQ_SOURCE_CTRL -- requirements
Module: irq_source_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, the number of external interrupt lines (2..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port irq_in  input  N_IRQ  asynchronous external interrupt lines, rising-edge sensitive.
REQ-005 SHALL have port mask_we  input  1  write strobe for the enable mask.
REQ-006 SHALL have port mask_wdata  input  N_IRQ  new enable mask (1 = enabled).
REQ-007 SHALL have port sel_ISR  input  1  ISR-entry indication from the interrupt controller.
REQ-008 SHALL have port ret_ISR  input  1  ISR-return indication from the interrupt controller.
REQ-009 SHALL have port interrupt_signal  output  1  active-low request to the interrupt controller.
REQ-010 SHALL have port irq_id  output  3  index of the claimed or in-service line.
REQ-011 SHALL have port irq_pending  output  N_IRQ  pending register.
REQ-012 SHALL have port irq_mask  output  N_IRQ  current enable mask.
REQ-013 SHALL have port in_service  output  1  high while an ISR is being serviced.

Function
REQ-014 SHALL pass each irq_in bit through a 2-flop synchronizer, then a third flop for edge detection.
- A rising edge SHALL be registered 3 cycles after the input change.
REQ-015 SHALL set irq_pending[i] on a detected rising edge of line i, regardless of the mask.
REQ-016 On mask_we, irq_mask SHALL load mask_wdata on the next edge.
- Masking SHALL never clear pending bits.
REQ-017 SHALL use a fixed priority among pending & mask: the lowest index wins.
REQ-018 SHALL implement the FSM IDLE, REQ, SERVICE, RETURN.
REQ-019 IDLE->REQ when (irq_pending & irq_mask)!=0.
- On this transition, irq_id SHALL latch the winning index.
- irq_id SHALL stay frozen until the next IDLE->REQ.
REQ-020 SHALL hold interrupt_signal=0 exactly while in REQ; it SHALL be 1 in every other state.
REQ-021 REQ->SERVICE on the first cycle that sel_ISR=1.
- Also clear irq_pending[irq_id].
- Set in_service=1.
REQ-022 If a new edge on line irq_id coincides with the clearing cycle, set SHALL win and the bit SHALL stay pending.
REQ-023 If line irq_id becomes masked while in REQ, the request SHALL still complete; no withdrawal.
REQ-024 SERVICE->RETURN when ret_ISR=1.
REQ-025 RETURN->IDLE when ret_ISR=0.
- Clear in_service on this transition.
- A new request SHALL NOT be raised earlier than 1 cycle after returning to IDLE.
REQ-026 SHALL NOT support nesting: edges arriving in SERVICE or RETURN SHALL only set pending bits.
REQ-027 irq_id SHALL be zero-extended when N_IRQ<8; priority logic SHALL ignore bits >= N_IRQ.

Reset
REQ-028 On nrst=0 at a clock edge, the following SHALL hold:
- State=IDLE.
- interrupt_signal=1.
- irq_id=0, irq_pending=0, irq_mask=0 (all disabled).
- in_service=0.
- Synchronizer and edge flops=0.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL abandon the request and discard all pending bits.
- An irq_in line held high through reset SHALL NOT generate an edge after reset.

Structure
REQ-030 SHALL place the FSM state encoding (2-bit) and the IRQ_ID_W=3 constant in the shared package.
REQ-031 SHALL instantiate one sub-module per line, irq_sync_edge (synchronizer plus edge detector), via a generate loop.
- All remaining logic SHALL reside in irq_source_ctrl.

Verification
REQ-032 Mask=8'hFF, pulse irq_in[5] 0->1 at cycle 10: interrupt_signal SHALL go low at cycle 14 with irq_id=5; sel_ISR=1 SHALL set it high next cycle with irq_pending[5]=0.
REQ-033 Edges on lines 6 and 2 in the same cycle: irq_id SHALL be 2; after ret_ISR rises and falls, a second request with irq_id=6 SHALL follow.
REQ-034 Mask=8'h00 and edge on line 3: irq_pending=8'h08 and interrupt_signal SHALL stay 1; writing mask=8'h08 SHALL lower interrupt_signal 1 cycle later.
REQ-035 Edge on line 4 in the same cycle sel_ISR claims line 4: in_service=1 and irq_pending[4] SHALL remain 1; after return, line 4 SHALL be requested again.
REQ-036 Assert nrst=0 during SERVICE with irq_in[1] held high: all outputs SHALL return to reset values; no request SHALL occur after reset until a new 0->1 on irq_in[1].
